// File: rtl/var_state_ctrl.sv
// Phase sequencer for a var_state array: decide -> imply -> analyze -> backtrack,
// owns the decision level and reports SAT/UNSAT/timeout through a start/done handshake.
module var_state_ctrl #(
  parameter int unsigned NUM_VARS  = 4,
  parameter int unsigned WIDTH_LVL = 10,
  parameter int unsigned MAX_IMPLY = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [NUM_VARS*3-1:0] var_value_i,
  input  logic                  find_imply_i,
  input  logic                  find_conflict_i,
  input  logic [WIDTH_LVL-1:0]  max_lvl_i,
  output logic [NUM_VARS-1:0]   index_decided_o,
  output logic [WIDTH_LVL-1:0]  cur_lvl_o,
  output logic                  apply_imply_o,
  output logic                  apply_analyze_o,
  output logic                  apply_bkt_o,
  output logic [WIDTH_LVL-1:0]  bkt_lvl_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sat_o,
  output logic                  unsat_o,
  output logic                  timeout_o
);

  localparam int unsigned CNT_W = $clog2(MAX_IMPLY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_IMPLY, S_DECIDE, S_ANALYZE, S_ANA_WAIT, S_BKT, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH_LVL-1:0] cur_lvl_q, cur_lvl_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_VARS-1:0]  dec_q, dec_d;
  logic                 settle_q, settle_d;
  logic                 sat_q, sat_d;
  logic                 unsat_q, unsat_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 free_found;
  logic [NUM_VARS-1:0]  free_onehot;
  logic                 unused_value_bits;

  assign unused_value_bits = ^var_value_i;

  // Lowest-index unassigned variable (var0 sits in the MSBs).
  always_comb begin
    free_found  = 1'b0;
    free_onehot = '0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      if (!free_found && var_value_i[(NUM_VARS-1-i)*3 +: 2] == 2'b00) begin
        free_found                  = 1'b1;
        free_onehot[NUM_VARS-1-i]   = 1'b1;
      end
    end
  end

  // The cycle right after a decision is a settle cycle: the array has not yet
  // seen the decided variable, so its find_* flags are stale and ignored.
  always_comb begin
    state_d   = state_q;
    cur_lvl_d = cur_lvl_q;
    bkt_lvl_d = bkt_lvl_q;
    cnt_d     = cnt_q;
    dec_d     = '0;
    settle_d  = 1'b0;
    sat_d     = sat_q;
    unsat_d   = unsat_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_IMPLY;
          cur_lvl_d = '0;
          cnt_d     = '0;
          sat_d     = 1'b0;
          unsat_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_IMPLY: begin
        if (settle_q) begin
          state_d = S_IMPLY;
        end else if (find_conflict_i) begin
          state_d = S_ANALYZE;
        end else if (find_imply_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_IMPLY - 1)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end else begin
          state_d = S_DECIDE;
          cnt_d   = '0;
        end
      end
      S_DECIDE: begin
        if (!free_found) begin
          state_d = S_DONE;
          sat_d   = 1'b1;
        end else if (cur_lvl_q == '1) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d   = S_IMPLY;
          dec_d     = free_onehot;
          cur_lvl_d = cur_lvl_q + WIDTH_LVL'(1);
          settle_d  = 1'b1;
        end
      end
      S_ANALYZE: begin
        if (cur_lvl_q == '0) begin
          state_d = S_DONE;
          unsat_d = 1'b1;
        end else begin
          state_d = S_ANA_WAIT;
        end
      end
      S_ANA_WAIT: begin
        bkt_lvl_d = (max_lvl_i >= cur_lvl_q) ? cur_lvl_q - WIDTH_LVL'(1) : max_lvl_i;
        state_d   = S_BKT;
      end
      S_BKT: begin
        cur_lvl_d = bkt_lvl_q;
        cnt_d     = '0;
        state_d   = S_IMPLY;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_lvl_q <= '0;
      bkt_lvl_q <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      settle_q  <= 1'b0;
      sat_q     <= 1'b0;
      unsat_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_lvl_q <= cur_lvl_d;
      bkt_lvl_q <= bkt_lvl_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      settle_q  <= settle_d;
      sat_q     <= sat_d;
      unsat_q   <= unsat_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Array strobes decode the current state so the array acts in the same cycle.
  assign apply_imply_o   = !rst && (state_q == S_IMPLY) && !settle_q
                           && !find_conflict_i && find_imply_i;
  assign apply_analyze_o = !rst && (state_q == S_ANALYZE) && (cur_lvl_q != '0);
  assign apply_bkt_o     = !rst && (state_q == S_BKT);

  assign index_decided_o = dec_q;
  assign cur_lvl_o       = cur_lvl_q;
  assign bkt_lvl_o       = bkt_lvl_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sat_o           = sat_q;
  assign unsat_o         = unsat_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_var_state_ctrl.sv
// Bench for var_state_ctrl: small var_state array model plus a scoreboard of
// expected decisions and results, compared when the DUT pulses them.
module tb_var_state_ctrl;

  localparam int unsigned NV = 4;
  localparam int unsigned WL = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [NV*3-1:0] var_value_i;
  logic            find_imply_i;
  logic            find_conflict_i;
  logic [WL-1:0]   max_lvl_i;
  logic [NV-1:0]   index_decided_o;
  logic [WL-1:0]   cur_lvl_o;
  logic            apply_imply_o;
  logic            apply_analyze_o;
  logic            apply_bkt_o;
  logic [WL-1:0]   bkt_lvl_o;
  logic            busy_o;
  logic            done_o;
  logic            sat_o;
  logic            unsat_o;
  logic            timeout_o;

  var_state_ctrl #(.NUM_VARS(NV), .WIDTH_LVL(WL), .MAX_IMPLY(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .var_value_i(var_value_i),
    .find_imply_i(find_imply_i), .find_conflict_i(find_conflict_i), .max_lvl_i(max_lvl_i),
    .index_decided_o(index_decided_o), .cur_lvl_o(cur_lvl_o),
    .apply_imply_o(apply_imply_o), .apply_analyze_o(apply_analyze_o),
    .apply_bkt_o(apply_bkt_o), .bkt_lvl_o(bkt_lvl_o), .busy_o(busy_o),
    .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV-1:0] idx;
    logic [WL-1:0] lvl;
  } dec_t;

  dec_t       exp_dec[$];
  logic [2:0] exp_res[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cnt_imply = 0, cnt_ana = 0, cnt_bkt = 0, cnt_done = 0;

  logic [NV-1:0] asg;
  logic [WL-1:0] vlvl [NV];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Array model: decided vars become assigned, backtrack frees vars above bkt_lvl.
  always_comb begin
    for (int i = 0; i < NV; i++) var_value_i[(NV-1-i)*3 +: 3] = asg[i] ? 3'b001 : 3'b000;
  end

  always @(posedge clk) begin
    if (rst) begin
      asg <= '0;
    end else begin
      for (int i = 0; i < NV; i++) begin
        if (index_decided_o[NV-1-i]) begin
          asg[i]  <= 1'b1;
          vlvl[i] <= cur_lvl_o;
        end
        if (apply_bkt_o && asg[i] && vlvl[i] > bkt_lvl_o) asg[i] <= 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (apply_imply_o)   cnt_imply++;
      if (apply_analyze_o) cnt_ana++;
      if (apply_bkt_o)     cnt_bkt++;
      if (apply_imply_o || apply_analyze_o || apply_bkt_o || (|index_decided_o))
        check_eq("strobe_excl",
                 32'($countones({apply_imply_o, apply_analyze_o, apply_bkt_o, index_decided_o})), 32'd1);
      if (|index_decided_o) begin
        if (exp_dec.size() == 0) begin
          check_eq("dec_unexpected", 32'(index_decided_o), 32'd0);
        end else begin
          dec_t e;
          e = exp_dec.pop_front();
          check_eq("dec_idx", 32'(index_decided_o), 32'(e.idx));
          check_eq("dec_lvl", 32'(cur_lvl_o), 32'(e.lvl));
        end
      end
      if (done_o) begin
        cnt_done++;
        if (exp_res.size() == 0) begin
          check_eq("done_unexpected", 32'(done_o), 32'd0);
        end else begin
          logic [2:0] r;
          r = exp_res.pop_front();
          check_eq("result_flags", 32'({sat_o, unsat_o, timeout_o}), 32'(r));
          check_eq("busy_at_done", 32'(busy_o), 32'd0);
        end
      end
    end
  end

  function automatic logic sel_sig(input int sel, input logic [NV-1:0] idx);
    case (sel)
      0:       return done_o;
      1:       return apply_analyze_o;
      2:       return apply_bkt_o;
      default: return index_decided_o == idx;
    endcase
  endfunction

  // Bounded wait for a DUT event, sampled on negedges.
  task automatic wait_ev(input int sel, input logic [NV-1:0] idx, input string tag);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sel_sig(sel, idx)) return;
    end
    check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_dec(input logic [NV-1:0] idx, input int lvl);
    dec_t e;
    e.idx = idx;
    e.lvl = WL'(lvl);
    exp_dec.push_back(e);
  endtask

  int base;

  initial begin
    rst = 1'b1; start_i = 1'b0; find_imply_i = 1'b0; find_conflict_i = 1'b0; max_lvl_i = '0;

    // 1: reset / idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(cnt_done), 32'd0);
    check_eq("rst_cur_lvl", 32'(cur_lvl_o), 32'd0);
    check_eq("rst_bkt_lvl", 32'(bkt_lvl_o), 32'd0);
    check_eq("rst_flags", 32'({sat_o, unsat_o, timeout_o}), 32'd0);
    check_eq("rst_strobes",
             32'({index_decided_o, apply_imply_o, apply_analyze_o, apply_bkt_o}), 32'd0);

    // 2: all free, no implications -> four decisions then SAT; a second start is dropped
    push_dec(4'b1000, 1); push_dec(4'b0100, 2); push_dec(4'b0010, 3); push_dec(4'b0001, 4);
    exp_res.push_back(3'b100);
    pulse_start();
    check_eq("busy_after_start", 32'(busy_o), 32'd1);
    pulse_start();
    wait_ev(0, '0, "sat_done_timeout");
    repeat (2) @(negedge clk);
    check_eq("sat_held", 32'(sat_o), 32'd1);
    check_eq("done_one_cycle", 32'(done_o), 32'd0);
    check_eq("sat_dec_drained", 32'(exp_dec.size()), 32'd0);

    // 3: conflict after the 2nd decision, backtrack to level 1, then finish SAT
    do_reset(1);
    push_dec(4'b1000, 1); push_dec(4'b0100, 2);
    pulse_start();
    check_eq("flags_cleared", 32'(sat_o), 32'd0);
    wait_ev(3, 4'b0100, "dec2_timeout");
    find_conflict_i = 1'b1;
    max_lvl_i = WL'(1);
    base = cnt_ana;
    wait_ev(1, '0, "analyze_timeout");
    find_conflict_i = 1'b0;
    check_eq("analyze_lvl", 32'(cur_lvl_o), 32'd2);
    wait_ev(2, '0, "bkt_timeout");
    check_eq("bkt_lvl", 32'(bkt_lvl_o), 32'd1);
    check_eq("analyze_once", 32'(cnt_ana - base), 32'd1);
    push_dec(4'b0100, 2); push_dec(4'b0010, 3); push_dec(4'b0001, 4);
    exp_res.push_back(3'b100);
    @(negedge clk);
    check_eq("lvl_after_bkt", 32'(cur_lvl_o), 32'd1);
    check_eq("busy_after_bkt", 32'(busy_o), 32'd1);
    wait_ev(0, '0, "bkt_sat_timeout");

    // 4: conflict together with an implication at level 0 -> UNSAT, no analyze, no imply
    do_reset(1);
    find_conflict_i = 1'b1;
    find_imply_i    = 1'b1;
    exp_res.push_back(3'b010);
    base = cnt_ana + cnt_imply;
    pulse_start();
    wait_ev(0, '0, "unsat_timeout");
    check_eq("unsat_no_strobes", 32'(cnt_ana + cnt_imply - base), 32'd0);
    find_conflict_i = 1'b0;
    find_imply_i    = 1'b0;

    // 5: implications never stop -> exactly 8 apply_imply cycles then timeout
    do_reset(1);
    find_imply_i = 1'b1;
    exp_res.push_back(3'b001);
    base = cnt_imply;
    pulse_start();
    wait_ev(0, '0, "imply_to_timeout");
    check_eq("imply_count", 32'(cnt_imply - base), 32'd8);
    find_imply_i = 1'b0;

    // 6: clamp of max_lvl 5 at level 3, then reset during BKT
    do_reset(1);
    push_dec(4'b1000, 1); push_dec(4'b0100, 2); push_dec(4'b0010, 3);
    pulse_start();
    wait_ev(3, 4'b0010, "dec3_timeout");
    find_conflict_i = 1'b1;
    max_lvl_i = WL'(5);
    wait_ev(1, '0, "analyze2_timeout");
    find_conflict_i = 1'b0;
    wait_ev(2, '0, "bkt2_timeout");
    check_eq("bkt_clamped", 32'(bkt_lvl_o), 32'd2);
    check_eq("bkt_cur_lvl", 32'(cur_lvl_o), 32'd3);
    base = cnt_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", 32'(busy_o), 32'd0);
    check_eq("midrst_cur_lvl", 32'(cur_lvl_o), 32'd0);
    check_eq("midrst_bkt_lvl", 32'(bkt_lvl_o), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("midrst_no_done", 32'(cnt_done - base), 32'd0);
    check_eq("midrst_idle_strobes", 32'({index_decided_o, apply_bkt_o, busy_o}), 32'd0);
    check_eq("queues_drained", 32'(exp_dec.size() + exp_res.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
